// File: rtl/copier_pkg.sv
// copier_pkg: shared constants and types for the byte-lane copier sequencer.
package copier_pkg;
  localparam int LANES = 4;
  localparam int WIDTH = 8 * LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } copier_state_t;

  typedef logic [LANES-1:0] lane_mask_t;
endpackage

// File: rtl/copier_rr_arb2.sv
// copier_rr_arb2: two-requester round-robin arbiter. The pointer names the
// requester that wins a tie and moves to the other requester after every grant.
module copier_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);
  logic r_ptr;

  // Tie goes to the pointer owner; a lone requester always wins.
  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) o_grant = r_ptr ? 2'b10 : 2'b01;
  end

  // Pointer flips to the requester that did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_ptr <= 1'b0;
    else if (i_accept && |o_grant)  r_ptr <= ~o_grant[1];
  end
endmodule

// File: rtl/copier_ctrl.sv
// copier_ctrl: arbitrates two requesters onto one byte-lane copier, sequences
// it (parallel or one lane per cycle) and returns Y1/Y2 on a valid/ready channel.
// Optional feature macro: COPIER_CTRL_STEP_EN enables byte-serial (STEP) mode.
module copier_ctrl #(
  parameter int WIDTH = copier_pkg::WIDTH,
  parameter int LANES = copier_pkg::LANES,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [LANES-1:0] req0_mask,
  input  logic             req0_neg,
  input  logic             req0_step,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic [WIDTH-1:0] req0_c,
  input  logic [WIDTH-1:0] req0_d,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [LANES-1:0] req1_mask,
  input  logic             req1_neg,
  input  logic             req1_step,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic [WIDTH-1:0] req1_c,
  input  logic [WIDTH-1:0] req1_d,
  output logic [LANES-1:0] cp_select,
  output logic             cp_neg,
  output logic [WIDTH-1:0] cp_c,
  output logic [WIDTH-1:0] cp_d,
  input  logic [WIDTH-1:0] cp_y1,
  input  logic [WIDTH-1:0] cp_y2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y1,
  output logic [WIDTH-1:0] rsp_y2,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_src,
  output logic             busy
);
  import copier_pkg::*;

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  copier_state_t    r_state, w_state_nxt;
  logic [1:0]       w_valid, w_grant;
  logic             w_accept, w_src;
  logic [LANES-1:0] w_req_mask, r_mask;
  logic             w_req_neg, r_neg;
  logic [TAG_W-1:0] w_req_tag, r_tag;
  logic [WIDTH-1:0] w_req_c, w_req_d, r_c, r_d, r_y1, r_y2;
  logic             r_src;
  logic             w_step_go, w_step_last;
  logic [LANES-1:0] w_step_sel;

  assign w_valid  = {req1_valid, req0_valid};
  // Ready is held low while reset is asserted so every output is quiet in reset.
  assign w_accept = rst_n && (r_state == IDLE) && (|w_valid);
  assign w_src    = w_grant[1];

  assign w_req_mask = w_src ? req1_mask : req0_mask;
  assign w_req_neg  = w_src ? req1_neg  : req0_neg;
  assign w_req_tag  = w_src ? req1_tag  : req0_tag;
  assign w_req_c    = w_src ? req1_c    : req0_c;
  assign w_req_d    = w_src ? req1_d    : req0_d;

  copier_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (w_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

`ifdef COPIER_CTRL_STEP_EN
  logic [IDX_W-1:0] r_idx, w_first_idx, w_next_idx;
  logic             w_has_next;
  logic             w_req_step;

  assign w_req_step = w_src ? req1_step : req0_step;

  // Lowest set bit of the incoming mask seeds the index; next set bit above r_idx advances it.
  always_comb begin
    w_first_idx = '0;
    w_next_idx  = r_idx;
    w_has_next  = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_req_mask[i]) w_first_idx = IDX_W'(i);
      if (r_mask[i] && (i > int'(r_idx))) begin
        w_has_next = 1'b1;
        w_next_idx = IDX_W'(i);
      end
    end
  end

  // A zero mask has no lane to walk, so it takes the RUN path.
  assign w_step_go   = w_req_step && (|w_req_mask);
  assign w_step_last = !w_has_next;
  assign w_step_sel  = LANES'(1) << r_idx;

  // Lane index: seeded on accept, advanced every STEP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_idx <= '0;
    else if (w_accept)         r_idx <= w_first_idx;
    else if (r_state == STEP)  r_idx <= w_next_idx;
  end
`else
  // Step requests are ignored in this build; ports kept for interface parity.
  logic w_unused_step;
  assign w_unused_step = req0_step | req1_step;
  assign w_step_go     = 1'b0;
  assign w_step_last   = 1'b1;
  assign w_step_sel    = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_step_go ? STEP : RUN;
      RUN:     w_state_nxt = DONE;
      STEP:    if (w_step_last) w_state_nxt = DONE;
      DONE:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture from the granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_neg  <= 1'b0;
      r_tag  <= '0;
      r_c    <= '0;
      r_d    <= '0;
      r_src  <= 1'b0;
    end else if (w_accept) begin
      r_mask <= w_req_mask;
      r_neg  <= w_req_neg;
      r_tag  <= w_req_tag;
      r_c    <= w_req_c;
      r_d    <= w_req_d;
      r_src  <= w_src;
    end
  end

  // Result registers: cleared on accept, loaded in RUN, accumulated lane by lane in STEP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y1 <= '0;
      r_y2 <= '0;
    end else if (w_accept) begin
      r_y1 <= '0;
      r_y2 <= '0;
    end else if (r_state == RUN) begin
      r_y1 <= cp_y1;
      r_y2 <= cp_y2;
    end else if (r_state == STEP) begin
      r_y1 <= r_y1 | cp_y1;
      r_y2 <= r_y2 | cp_y2;
    end
  end

  // Output decode: copier drive only while working, response fields only in DONE.
  always_comb begin
    req0_ready = w_accept & w_grant[0];
    req1_ready = w_accept & w_grant[1];
    cp_select  = '0;
    cp_neg     = 1'b0;
    cp_c       = '0;
    cp_d       = '0;
    rsp_valid  = 1'b0;
    rsp_y1     = '0;
    rsp_y2     = '0;
    rsp_tag    = '0;
    rsp_src    = 1'b0;
    busy       = (r_state != IDLE);
    case (r_state)
      RUN: begin
        cp_select = r_mask;
        cp_neg    = r_neg;
        cp_c      = r_c;
        cp_d      = r_d;
      end
      STEP: begin
        cp_select = w_step_sel;
        cp_neg    = r_neg;
        cp_c      = r_c;
        cp_d      = r_d;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_y1    = r_y1;
        rsp_y2    = r_y2;
        rsp_tag   = r_tag;
        rsp_src   = r_src;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_copier_ctrl.sv
// tb_copier_ctrl: directed bench with a byte-lane copier model and a response scoreboard.
module tb_copier_ctrl;
`ifdef COPIER_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_neg, req0_step;
  logic [3:0]  req0_mask, req0_tag;
  logic [31:0] req0_c, req0_d;
  logic        req1_valid, req1_ready, req1_neg, req1_step;
  logic [3:0]  req1_mask, req1_tag;
  logic [31:0] req1_c, req1_d;
  logic [3:0]  cp_select;
  logic        cp_neg;
  logic [31:0] cp_c, cp_d, cp_y1, cp_y2;
  logic        rsp_valid, rsp_ready, rsp_src, busy;
  logic [31:0] rsp_y1, rsp_y2;
  logic [3:0]  rsp_tag;

  typedef struct {
    logic [31:0] y1;
    logic [31:0] y2;
    logic [3:0]  tag;
    logic        src;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] sel_log[$];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  copier_ctrl #(.WIDTH(32), .LANES(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mask(req0_mask),
    .req0_neg(req0_neg), .req0_step(req0_step), .req0_tag(req0_tag),
    .req0_c(req0_c), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mask(req1_mask),
    .req1_neg(req1_neg), .req1_step(req1_step), .req1_tag(req1_tag),
    .req1_c(req1_c), .req1_d(req1_d),
    .cp_select(cp_select), .cp_neg(cp_neg), .cp_c(cp_c), .cp_d(cp_d),
    .cp_y1(cp_y1), .cp_y2(cp_y2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y1(rsp_y1), .rsp_y2(rsp_y2),
    .rsp_tag(rsp_tag), .rsp_src(rsp_src), .busy(busy)
  );

  // Copier behaviour: selected bytes pass or invert, the rest are zero.
  function automatic logic [31:0] cpy(input logic [3:0] m, input logic ng, input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = ng ? ~v[8*i +: 8] : v[8*i +: 8];
    return r;
  endfunction

  assign cp_y1 = cpy(cp_select, cp_neg, cp_c);
  assign cp_y2 = cpy(cp_select, cp_neg, cp_d);

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // Continuous protocol checks.
  always @(negedge clk) begin
    chk("one_ready", req0_ready & req1_ready, 0);
    chk("ready_only_idle", busy & (req0_ready | req1_ready), 0);
    if (!rsp_valid) chk("rsp_zero_when_invalid", |{rsp_y1, rsp_y2, rsp_tag, rsp_src}, 0);
    if (cp_select != 4'b0) sel_log.push_back(cp_select);
  end

  task automatic sb_push(input logic src, input logic [3:0] m, input logic ng,
                         input logic [3:0] tg, input logic [31:0] c, input logic [31:0] d);
    exp_t e;
    e.y1 = cpy(m, ng, c);
    e.y2 = cpy(m, ng, d);
    e.tag = tg;
    e.src = src;
    sb.push_back(e);
  endtask

  task automatic set_req(input int n, input logic [3:0] m, input logic ng, input logic st,
                         input logic [3:0] tg, input logic [31:0] c, input logic [31:0] d);
    if (n == 0) begin
      req0_mask = m; req0_neg = ng; req0_step = st; req0_tag = tg;
      req0_c = c; req0_d = d; req0_valid = 1'b1;
    end else begin
      req1_mask = m; req1_neg = ng; req1_step = st; req1_tag = tg;
      req1_c = c; req1_d = d; req1_valid = 1'b1;
    end
    #1;
  endtask

  task automatic wait_ready(input int n, input string nm);
    int c = 0;
    while (!((n == 0) ? req0_ready : req1_ready) && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_ready"}, (n == 0) ? req0_ready : req1_ready, 1);
  endtask

  task automatic check_rsp(input string nm);
    exp_t e;
    chk({nm, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({nm, "_y1"}, rsp_y1, e.y1);
      chk({nm, "_y2"}, rsp_y2, e.y2);
      chk({nm, "_tag"}, rsp_tag, e.tag);
      chk({nm, "_src"}, rsp_src, e.src);
    end
  endtask

  // One request from one port with rsp_ready high; checks latency and result.
  task automatic run_op(input int n, input logic [3:0] m, input logic ng, input logic st,
                        input logic [3:0] tg, input logic [31:0] c, input logic [31:0] d,
                        input string nm);
    int k;
    int exp_lat;
    set_req(n, m, ng, st, tg, c, d);
    sb_push(n[0], m, ng, tg, c, d);
    wait_ready(n, nm);
    @(posedge clk);
    @(negedge clk);
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    exp_lat = (STEP_EN && st && (m != 4'b0)) ? 1 + $countones(m) : 2;
    chk({nm, "_latency"}, k, exp_lat);
    check_rsp(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Collect n responses while requesters stay valid, then drop both valids.
  task automatic drain(input int nresp, input string nm);
    int got = 0;
    int cyc = 0;
    while (got < nresp && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid && rsp_ready) begin
        check_rsp(nm);
        got++;
      end
    end
    chk({nm, "_count"}, got, nresp);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_mask = 0; req0_neg = 0; req0_step = 0; req0_tag = 0; req0_c = 0; req0_d = 0;
    req1_valid = 0; req1_mask = 0; req1_neg = 0; req1_step = 0; req1_tag = 0; req1_c = 0; req1_d = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cp_select", cp_select, 0);
    chk("rst_cp_c", cp_c, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention straight after reset: grants go 0,1,0,1
    set_req(0, 4'b0101, 1'b0, 1'b0, 4'd1, 32'h01020304, 32'h10203040);
    set_req(1, 4'b1111, 1'b1, 1'b0, 4'd2, 32'hF0F0F0F0, 32'h12345678);
    sb_push(1'b0, 4'b0101, 1'b0, 4'd1, 32'h01020304, 32'h10203040);
    sb_push(1'b1, 4'b1111, 1'b1, 4'd2, 32'hF0F0F0F0, 32'h12345678);
    sb_push(1'b0, 4'b0101, 1'b0, 4'd1, 32'h01020304, 32'h10203040);
    sb_push(1'b1, 4'b1111, 1'b1, 4'd2, 32'hF0F0F0F0, 32'h12345678);
    drain(4, "contend");
    @(posedge clk);
    @(negedge clk);

    // Parallel copy
    run_op(0, 4'b0101, 1'b0, 1'b0, 4'd3, 32'h11223344, 32'hAABBCCDD, "par");

    // Negated step on port 1
    sel_log.delete();
    run_op(1, 4'b1010, 1'b1, 1'b1, 4'd5, 32'h00000000, 32'h12345678, "negstep");
`ifdef COPIER_CTRL_STEP_EN
    chk("negstep_sel_n", sel_log.size(), 2);
    chk("negstep_sel0", (sel_log.size() > 0) ? sel_log[0] : 4'hF, 4'b0010);
    chk("negstep_sel1", (sel_log.size() > 1) ? sel_log[1] : 4'hF, 4'b1000);
`else
    chk("negstep_sel_n", sel_log.size(), 1);
    chk("negstep_sel0", (sel_log.size() > 0) ? sel_log[0] : 4'hF, 4'b1010);
`endif

    // Zero mask in step mode takes RUN and returns zeros
    run_op(0, 4'b0000, 1'b1, 1'b1, 4'd7, 32'hDEADBEEF, 32'hCAFEF00D, "zero");
    // Three-lane step, plus full-mask negate
    run_op(1, 4'b1011, 1'b0, 1'b1, 4'd8, 32'h89ABCDEF, 32'h76543210, "step3");
    run_op(0, 4'b1111, 1'b1, 1'b0, 4'd6, 32'h0F0F00FF, 32'h80000001, "fullneg");

    // Backpressure: result held, no accepts, busy high
    rsp_ready = 1'b0;
    set_req(0, 4'b0011, 1'b0, 1'b0, 4'd9, 32'hCAFEBABE, 32'h01020304);
    sb_push(1'b0, 4'b0011, 1'b0, 4'd9, 32'hCAFEBABE, 32'h01020304);
    wait_ready(0, "bp");
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    set_req(1, 4'b1100, 1'b0, 1'b0, 4'd10, 32'hDEADBEEF, 32'h55667788);
    sb_push(1'b1, 4'b1100, 1'b0, 4'd10, 32'hDEADBEEF, 32'h55667788);
    c = 0;
    while (!rsp_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("bp_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_y1", rsp_y1, cpy(4'b0011, 1'b0, 32'hCAFEBABE));
      chk("bp_hold_y2", rsp_y2, cpy(4'b0011, 1'b0, 32'h01020304));
      chk("bp_ready_low", {req0_ready, req1_ready}, 0);
      chk("bp_busy", busy, 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check_rsp("bp");
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_ready", req1_ready, 1);
    chk("bp_next_idle", busy, 0);
    drain(1, "bp_next");
    @(posedge clk);
    @(negedge clk);

    // Reset during the second working cycle of a step op
    set_req(1, 4'b1010, 1'b1, 1'b1, 4'd11, 32'h00000000, 32'hFFFFFFFF);
    wait_ready(1, "rstmid");
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_cp_select", cp_select, 0);
    chk("rstmid_cp_neg", cp_neg, 0);
    chk("rstmid_cp_c", cp_c, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_no_stale", rsp_valid, 0);
    end
    sb.delete();
    set_req(0, 4'b1001, 1'b0, 1'b0, 4'd12, 32'hA1B2C3D4, 32'h0BADCAFE);
    set_req(1, 4'b0110, 1'b1, 1'b0, 4'd13, 32'h33333333, 32'h44444444);
    chk("rstmid_ptr_r0", req0_ready, 1);
    chk("rstmid_ptr_r1", req1_ready, 0);
    sb_push(1'b0, 4'b1001, 1'b0, 4'd12, 32'hA1B2C3D4, 32'h0BADCAFE);
    sb_push(1'b1, 4'b0110, 1'b1, 4'd13, 32'h33333333, 32'h44444444);
    drain(2, "post_rst");
    @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
